// File: rtl/div_block.sv
// div_block: iterative unsigned restoring divider, one quotient bit per clock.
// A start is taken whenever no division is running; the result registers hold
// their value until the next accepted start replaces it.
module div_block #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;

  // Working registers. The partial remainder is always smaller than the
  // divisor after a step, so its extra top bit is always zero and is not
  // stored; the trial difference keeps the full WIDTH+1 bits.
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;

  logic             accept;
  logic             finish;
  logic             zero_div;

  assign zero_div = (divisor == '0);

  // Trial subtract: keep the difference when it is non-negative, else restore.
  always_comb begin
    trial = {r_reg, q_reg[WIDTH-1]};
    diff  = trial - {1'b0, d_reg};
    if (!diff[WIDTH]) begin
      r_step = diff[WIDTH-1:0];
      q_step = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_step = trial[WIDTH-1:0];
      q_step = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_STEP) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = zero_div ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture and iteration; needs no reset since it is reloaded on every accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
    end else if (state == RUN) begin
      q_reg <= q_step;
      r_reg <= r_step;
    end
  end

  // Step counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (accept && zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else if (accept) begin
        div_by_zero <= 1'b0;
      end else if (finish) begin
        quotient    <= q_step;
        remainder   <= r_step;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
